// File: rtl/tone_pkg.sv
// Shared types, constants and helpers for the tone sample generator.
package tone_pkg;

    localparam logic [11:0] MIDSCALE   = 12'd2048;
    localparam logic [2:0]  SILENT_KEY = 3'd7;

    // Phase increments for C4..A4 with a 40 kHz sample rate and a 24-bit accumulator
    localparam logic [23:0] PINC [6] = '{24'd109734, 24'd123172, 24'd138253,
                                         24'd146477, 24'd164415, 24'd184549};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } tone_tx_state_t;

    function automatic logic [23:0] phaseInc(input logic [2:0] key);
        case (key)
            3'd0:    phaseInc = PINC[0];
            3'd1:    phaseInc = PINC[1];
            3'd2:    phaseInc = PINC[2];
            3'd3:    phaseInc = PINC[3];
            3'd4:    phaseInc = PINC[4];
            3'd5:    phaseInc = PINC[5];
            default: phaseInc = 24'd0;
        endcase
    endfunction

    function automatic logic [2:0] lowestKey(input logic [5:0] keys);
        casez (keys)
            6'b?????1: lowestKey = 3'd0;
            6'b????10: lowestKey = 3'd1;
            6'b???100: lowestKey = 3'd2;
            6'b??1000: lowestKey = 3'd3;
            6'b?10000: lowestKey = 3'd4;
            6'b100000: lowestKey = 3'd5;
            default:   lowestKey = SILENT_KEY;
        endcase
    endfunction

endpackage

// File: rtl/tone_dds_core.sv
// Phase accumulator with key-change reload and triangle mapping; the
// triangle output reflects the phase that the next tick will store.
module tone_dds_core
    import tone_pkg::*;
#(
    parameter int PHASE_W = 24
)
(
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        reload,
    input  logic [2:0]  keySel,
    output logic [11:0] triNext
);

    // Quarter-turn start point maps to midscale on the rising slope
    localparam logic [PHASE_W-1:0] RELOAD_PHASE = PHASE_W'(1) << (PHASE_W - 2);

    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phaseNext_s;
    logic [12:0]        phaseTop_s;

    // Next phase: reload on key change, otherwise advance (silence adds zero)
    always_comb begin
        phaseNext_s = phase_r;
        if (reload) begin
            phaseNext_s = RELOAD_PHASE;
        end else begin
            phaseNext_s = phase_r + PHASE_W'(phaseInc(keySel));
        end
    end

    assign phaseTop_s = phaseNext_s[PHASE_W-1 -: 13];
    assign triNext    = phaseTop_s[12] ? ~phaseTop_s[11:0] : phaseTop_s[11:0];

    // Phase register, stepped once per sample tick
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= RELOAD_PHASE;
        end else if (tick) begin
            phase_r <= phaseNext_s;
        end
    end

endmodule

// File: rtl/tone_sample_generator.sv
// Key-driven triangle tone source handing samples to the DAC SPI controller.
// Optional attack/release envelope is enabled by defining TONE_ENVELOPE_EN.
module tone_sample_generator
    import tone_pkg::*;
#(
    parameter int SAMPLE_DIV = 1250,
    parameter int PHASE_W    = 24
`ifdef TONE_ENVELOPE_EN
    ,
    parameter int ENV_STEP   = 40
`endif
)
(
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic [5:0]  input_KeyPressed,
    input  logic        dac_isBusy,
    input  logic        dac_transmitComplete,
    output logic [11:0] outputSample,
    output logic        sendSample_n,
    output logic [2:0]  activeKey,
    output logic [7:0]  overrunCount
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CNT_W-1:0] tickCount_r;
    logic             tick_s;
    logic [2:0]       keySel_s;
    logic [2:0]       soundKey_s;
    logic             reload_s;
    logic [11:0]      triNext_s;
    logic [11:0]      sampleNext_s;
    logic [11:0]      outputSample_r;
    logic [2:0]       activeKey_r;
    logic [7:0]       overrunCount_r;
    logic             sendSample_n_r;
    tone_tx_state_t   state_r;
    tone_tx_state_t   stateNext_s;

    // Sample-rate divider
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tickCount_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            tickCount_r <= {CNT_W{1'b0}};
        end else begin
            tickCount_r <= tickCount_r + CNT_W'(1);
        end
    end

    assign tick_s   = (tickCount_r == CNT_W'(SAMPLE_DIV - 1));
    assign keySel_s = lowestKey(input_KeyPressed);

`ifdef TONE_ENVELOPE_EN
    logic [7:0]         gain_r;
    logic [15:0]        envCount_r;
    logic signed [12:0] triDiff_s;
    logic signed [21:0] scaled_s;

    // Released notes keep sounding on the old key until the gain reaches zero
    always_comb begin
        if (keySel_s != SILENT_KEY) begin
            soundKey_s = keySel_s;
        end else if (gain_r != 8'd0) begin
            soundKey_s = activeKey_r;
        end else begin
            soundKey_s = SILENT_KEY;
        end
        reload_s     = (soundKey_s != activeKey_r) && (gain_r == 8'd0);
        triDiff_s    = $signed({1'b0, triNext_s}) - 13'sd2048;
        scaled_s     = (triDiff_s * $signed({1'b0, gain_r})) >>> 8;
        sampleNext_s = 12'(22'sd2048 + scaled_s);
    end

    // Gain ramps up while a key is held and down during release
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            gain_r     <= 8'd0;
            envCount_r <= 16'd0;
        end else if (tick_s) begin
            if (envCount_r == 16'(ENV_STEP - 1)) begin
                envCount_r <= 16'd0;
                if (keySel_s != SILENT_KEY) begin
                    if (gain_r != 8'd255) begin
                        gain_r <= gain_r + 8'd1;
                    end
                end else if (gain_r != 8'd0) begin
                    gain_r <= gain_r - 8'd1;
                end
            end else begin
                envCount_r <= envCount_r + 16'd1;
            end
        end
    end
`else
    // Full-scale output; silence is midscale immediately
    always_comb begin
        soundKey_s = keySel_s;
        reload_s   = (soundKey_s != activeKey_r);
        if (soundKey_s == SILENT_KEY) begin
            sampleNext_s = MIDSCALE;
        end else begin
            sampleNext_s = triNext_s;
        end
    end
`endif

    tone_dds_core #(
        .PHASE_W (PHASE_W)
    ) u_ddsCore (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .tick        (tick_s),
        .reload      (reload_s),
        .keySel      (soundKey_s),
        .triNext     (triNext_s)
    );

    // Handshake next-state
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick_s) stateNext_s = REQ;
                else        stateNext_s = IDLE;
            end
            REQ: begin
                if (dac_isBusy) stateNext_s = WAIT_DONE;
                else            stateNext_s = REQ;
            end
            WAIT_DONE: begin
                if (dac_transmitComplete) stateNext_s = IDLE;
                else                      stateNext_s = WAIT_DONE;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // State, request strobe, sample latch and overrun accounting
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            sendSample_n_r <= 1'b1;
            outputSample_r <= MIDSCALE;
            activeKey_r    <= SILENT_KEY;
            overrunCount_r <= 8'd0;
        end else begin
            state_r        <= stateNext_s;
            sendSample_n_r <= (stateNext_s != REQ);
            if (tick_s) begin
                activeKey_r <= soundKey_s;
                if (state_r == IDLE) begin
                    outputSample_r <= sampleNext_s;
                end else if (overrunCount_r != 8'd255) begin
                    overrunCount_r <= overrunCount_r + 8'd1;
                end
            end
        end
    end

    assign outputSample = outputSample_r;
    assign sendSample_n = sendSample_n_r;
    assign activeKey    = activeKey_r;
    assign overrunCount = overrunCount_r;

endmodule

// File: tb/tb_tone_sample_generator.sv
// Directed bench for tone_sample_generator with a simple DAC handshake model.
module tb_tone_sample_generator;

    localparam int SAMPLE_DIV = 10;

    logic        clock_50Mhz = 1'b0;
    logic        reset_n;
    logic [5:0]  input_KeyPressed;
    logic        dac_isBusy;
    logic        dac_transmitComplete;
    logic [11:0] outputSample;
    logic        sendSample_n;
    logic [2:0]  activeKey;
    logic [7:0]  overrunCount;

    int checkCount = 0;
    int errorCount = 0;
    int dacBusyLen = 5;
    int dacPhase;
    int dacCnt;
    logic        prevSend;
    logic [11:0] sampleQ[$];
    logic [2:0]  keyQ[$];

    tone_sample_generator #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clock_50Mhz          (clock_50Mhz),
        .reset_n              (reset_n),
        .input_KeyPressed     (input_KeyPressed),
        .dac_isBusy           (dac_isBusy),
        .dac_transmitComplete (dac_transmitComplete),
        .outputSample         (outputSample),
        .sendSample_n         (sendSample_n),
        .activeKey            (activeKey),
        .overrunCount         (overrunCount)
    );

    always #5 clock_50Mhz = ~clock_50Mhz;

    task automatic checkValue(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearQueues();
        sampleQ.delete();
        keyQ.delete();
    endtask

    task automatic waitSamples(input int n);
        int budget;
        budget = 0;
        while (sampleQ.size() < n && budget < 200) begin
            @(negedge clock_50Mhz);
            budget++;
        end
        if (sampleQ.size() < n) checkValue("sampleTimeout", sampleQ.size(), n);
    endtask

    // DAC model: busy two clocks after the request, completion pulse dacBusyLen clocks later
    initial begin
        dac_isBusy           = 1'b0;
        dac_transmitComplete = 1'b0;
        dacPhase             = 0;
        dacCnt               = 0;
        forever begin
            @(negedge clock_50Mhz);
            dac_transmitComplete = 1'b0;
            if (!reset_n) begin
                dacPhase   = 0;
                dac_isBusy = 1'b0;
            end else if (dacPhase == 0) begin
                if (!sendSample_n) dacPhase = 1;
            end else if (dacPhase == 1) begin
                dac_isBusy = 1'b1;
                dacCnt     = 0;
                dacPhase   = 2;
            end else begin
                dacCnt++;
                if (dacCnt >= dacBusyLen) begin
                    dac_isBusy           = 1'b0;
                    dac_transmitComplete = 1'b1;
                    dacPhase             = 0;
                end
            end
        end
    end

    // Record the sample and key presented with every new request
    initial begin
        prevSend = 1'b1;
        forever begin
            @(posedge clock_50Mhz);
            #1;
            if (prevSend && !sendSample_n) begin
                sampleQ.push_back(outputSample);
                keyQ.push_back(activeKey);
            end
            prevSend = sendSample_n;
        end
    end

    initial begin
        int o1, s1, waited;
        int expA[3];
        reset_n          = 1'b0;
        input_KeyPressed = 6'b000000;
        repeat (3) @(negedge clock_50Mhz);
        checkValue("rstSample", outputSample, 2048);
        checkValue("rstSend", sendSample_n, 1);
        checkValue("rstKey", activeKey, 7);
        checkValue("rstOverrun", overrunCount, 0);
        reset_n = 1'b1;

        // Silence
        clearQueues();
        waitSamples(3);
        for (int i = 0; i < 3; i++) begin
            checkValue("silenceSample", sampleQ[i], 2048);
            checkValue("silenceKey", keyQ[i], 7);
        end
        checkValue("silenceOverrun", overrunCount, 0);

        // Key 0: reload to midscale, then +109734 per tick
        @(negedge clock_50Mhz);
        input_KeyPressed = 6'b000001;
        clearQueues();
        waitSamples(3);
        expA = '{2048, 2101, 2155};
        for (int i = 0; i < 3; i++) checkValue("key0Sample", sampleQ[i], expA[i]);
        checkValue("key0Active", keyQ[2], 0);

        // Keys 2 and 5 pressed: key 2 wins, reload then +138253
        @(negedge clock_50Mhz);
        input_KeyPressed = 6'b100100;
        clearQueues();
        waitSamples(2);
        checkValue("key2First", sampleQ[0], 2048);
        checkValue("key2Second", sampleQ[1], 2115);
        checkValue("key2Active", keyQ[1], 2);

        // Release to silence
        @(negedge clock_50Mhz);
        input_KeyPressed = 6'b000000;
        clearQueues();
        waitSamples(2);
        checkValue("releaseSample", sampleQ[1], 2048);
        checkValue("releaseKey", keyQ[1], 7);

        // Slow DAC: two of every three ticks are dropped
        @(negedge clock_50Mhz);
        input_KeyPressed = 6'b000100;
        dacBusyLen       = 25;
        clearQueues();
        waitSamples(1);
        o1 = overrunCount;
        s1 = sampleQ.size();
        repeat (300) @(negedge clock_50Mhz);
        checkValue("slowRequests", sampleQ.size() - s1, 10);
        checkValue("slowOverruns", overrunCount - o1, 20);
        waited = 0;
        while (overrunCount != 8'd255 && waited < 6000) begin
            @(negedge clock_50Mhz);
            waited++;
        end
        checkValue("overrunSaturate", overrunCount, 255);
        repeat (100) @(negedge clock_50Mhz);
        checkValue("overrunHold", overrunCount, 255);

        // Reset during WAIT_DONE
        dacBusyLen = 5;
        repeat (60) @(negedge clock_50Mhz);
        input_KeyPressed = 6'b000001;
        clearQueues();
        waitSamples(2);
        checkValue("preRstSample", sampleQ[1], 2101);
        repeat (2) @(negedge clock_50Mhz);
        reset_n = 1'b0;
        #1;
        checkValue("midRstSend", sendSample_n, 1);
        checkValue("midRstSample", outputSample, 2048);
        checkValue("midRstKey", activeKey, 7);
        checkValue("midRstOverrun", overrunCount, 0);
        repeat (2) @(negedge clock_50Mhz);
        reset_n = 1'b1;
        waited  = 0;
        while (sendSample_n && waited < 50) begin
            @(negedge clock_50Mhz);
            waited++;
        end
        checkValue("firstReqDelay", waited, 10);
        checkValue("firstReqSample", outputSample, 2048);
        checkValue("firstReqKey", activeKey, 0);

        // Reset while the request is still pending
        reset_n = 1'b0;
        #1;
        checkValue("reqRstSend", sendSample_n, 1);
        repeat (2) @(negedge clock_50Mhz);
        reset_n = 1'b1;
        repeat (5) @(negedge clock_50Mhz);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
